block_transfer_sequencer: RTL

BLOCK_TRANSFER_SEQUENCER -- requirements
Module: block_transfer_sequencer

---
 rtl/block_transfer_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/block_transfer_sequencer.sv
// Block load/store sequencer: walks a register list and issues one memory word per set bit, then optional base writeback.
// Latency: start edge to done = N transfers (+1 writeback) + 1 cycles with zero-wait ack; empty list completes in 1 cycle.
// Backpressure: each transfer holds mem_req/mem_addr/mem_wdata stable until mem_ack; no other stall sources.
module block_transfer_sequencer #(
    parameter int NREGS = 16,
    parameter int AW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NREGS-1:0] reglist,
    input  logic [AW-1:0]    base,
    input  logic [3:0]       rn,
    input  logic             load,
    input  logic             up,
    input  logic             pre,
    input  logic             wb,
    output logic             busy,
    output logic             hold_pc,
    output logic             done,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [AW-1:0]    mem_wdata,
    input  logic             mem_ack,
    input  logic [AW-1:0]    mem_rdata,
    output logic [3:0]       rf_raddr,
    input  logic [AW-1:0]    rf_rdata,
    output logic             rf_we,
    output logic [3:0]       rf_waddr,
    output logic [AW-1:0]    rf_wdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [NREGS-1:0] list_q, list_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    final_q, final_d;
    logic [3:0]       rn_q, rn_d;
    logic             load_q, load_d;
    logic             do_wb_q, do_wb_d;

    logic [3:0]       cur_idx;
    logic [NREGS-1:0] list_rest;
    logic [AW-1:0]    span;
    logic [AW-1:0]    first_addr;

    // Total byte span of the block: four bytes per selected register.
    function automatic logic [AW-1:0] span_bytes(input logic [NREGS-1:0] v);
        logic [AW-1:0] s;
        s = '0;
        for (int i = 0; i < NREGS; i++) begin
            s = s + {{(AW-3){1'b0}}, v[i], 2'b00};
        end
        return s;
    endfunction

    always_comb begin
        span = span_bytes(reglist);
        case ({up, pre})
            2'b10:   first_addr = base;
            2'b11:   first_addr = base + AW'(4);
            2'b00:   first_addr = base - span + AW'(4);
            default: first_addr = base - span;
        endcase
    end

    // Lowest remaining set bit is the current register; ascending order falls out naturally.
    always_comb begin
        cur_idx = 4'd0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (list_q[i]) begin
                cur_idx = 4'(i);
            end
        end
    end

    assign list_rest = list_q & (list_q - NREGS'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            list_q  <= '0;
            addr_q  <= '0;
            final_q <= '0;
            rn_q    <= '0;
            load_q  <= 1'b0;
            do_wb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            list_q  <= list_d;
            addr_q  <= addr_d;
            final_q <= final_d;
            rn_q    <= rn_d;
            load_q  <= load_d;
            do_wb_q <= do_wb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        list_d    = list_q;
        addr_d    = addr_q;
        final_d   = final_q;
        rn_d      = rn_q;
        load_d    = load_q;
        do_wb_d   = do_wb_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rf_raddr  = 4'd0;
        rf_we     = 1'b0;
        rf_waddr  = 4'd0;
        rf_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    list_d  = reglist;
                    addr_d  = first_addr;
                    final_d = up ? (base + span) : (base - span);
                    rn_d    = rn;
                    load_d  = load;
                    // A load that overwrites the base register wins over writeback.
                    do_wb_d = wb && !(load && reglist[rn]);
                    state_d = (reglist != '0) ? XFER : DONE;
                end
            end
            XFER: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = !load_q;
                mem_addr = addr_q;
                rf_raddr = cur_idx;
                if (!load_q) begin
                    mem_wdata = rf_rdata;
                end
                if (mem_ack) begin
                    list_d = list_rest;
                    addr_d = addr_q + AW'(4);
                    if (load_q) begin
                        rf_we    = 1'b1;
                        rf_waddr = cur_idx;
                        rf_wdata = mem_rdata;
                    end
                    if (list_rest == '0) begin
                        state_d = do_wb_q ? WB : DONE;
                    end
                end
            end
            WB: begin
                busy     = 1'b1;
                rf_we    = 1'b1;
                rf_waddr = rn_q;
                rf_wdata = final_q;
                state_d  = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign hold_pc = busy;

endmodule
